// File: rtl/calc_seq_pkg.sv
// Shared types and defaults for the calculator sequencer: FSM states,
// default sizing and channel index names.
package calc_seq_pkg;

    localparam int W_DEF          = 32;
    localparam int NUM_PAR_DEF    = 5;
    localparam int NUM_CH_DEF     = 5;
    localparam int GAP_CYCLES_DEF = 20;
    localparam int TIMEOUT_DEF    = 4096;

    localparam int CH_X  = 0;
    localparam int CH_Y  = 1;
    localparam int CH_Z  = 2;
    localparam int CH_E0 = 3;
    localparam int CH_E1 = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT,
        CAPTURE,
        GAP,
        DONE,
        ERROR
    } seq_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/calc_params_sequencer_if.sv
// Request/response link between the sequencer (master) and the shared
// parameter calculator (slave).
interface calc_params_sequencer_if
    import calc_seq_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int NUM_PAR = NUM_PAR_DEF
);

    logic                          calc_start;
    logic [NUM_PAR-1:0][W-1:0]     calc_params;
    logic                          calc_finish;
    logic [NUM_PAR-1:0][W-1:0]     calc_result;

    modport master (
        output calc_start,
        output calc_params,
        input  calc_finish,
        input  calc_result
    );

    modport slave (
        input  calc_start,
        input  calc_params,
        output calc_finish,
        output calc_result
    );

endinterface

// File: rtl/calc_params_sequencer_down_counter.sv
// Loadable down counter with a zero flag; serves both the gap delay and
// the calculator timeout, which are never active at the same time.
module seq_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/calc_params_sequencer.sv
// Runs one shared speed/jerk/acc calculator over every enabled channel in
// turn, using a snapshot taken at start, and banks each result per channel.
module calc_params_sequencer
    import calc_seq_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int NUM_PAR    = NUM_PAR_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [NUM_CH-1:0]                     chan_en,
    input  logic [NUM_CH-1:0][NUM_PAR-1:0][W-1:0] params_in,
    calc_params_sequencer_if.master               calc,
    output logic [NUM_CH-1:0][NUM_PAR-1:0][W-1:0] new_params,
    output logic [NUM_CH-1:0]                     chan_done,
    output logic                                  busy,
    output logic                                  finish,
    output logic                                  timeout_err
);

    localparam int PTR_W = $clog2(NUM_CH + 1);
    localparam int CNT_W = $clog2(max2(TIMEOUT, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_t state, state_nxt;

    logic [PTR_W-1:0]                      ptr;
    logic [NUM_CH-1:0]                     snap_en;
    logic [NUM_CH-1:0][NUM_PAR-1:0][W-1:0] snap;
    logic [NUM_PAR-1:0][W-1:0]             calc_params_q;
    logic                                  calc_start_q;

    logic             snap_ld, skip, sel_ld, cap, clr_done;
    logic             cnt_ld, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    seq_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_ld),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping start overrides every other transition out of a non-idle state.
    always_comb begin
        state_nxt = state;
        snap_ld   = 1'b0;
        skip      = 1'b0;
        sel_ld    = 1'b0;
        cap       = 1'b0;
        clr_done  = 1'b0;
        cnt_ld    = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        if ((state != IDLE) && !start) begin
            state_nxt = IDLE;
            clr_done  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_ld   = 1'b1;
                        state_nxt = SELECT;
                    end
                end
                SELECT: begin
                    if (ptr == PTR_W'(NUM_CH)) begin
                        state_nxt = DONE;
                    end else if (!snap_en[ptr]) begin
                        skip = 1'b1;
                    end else begin
                        sel_ld    = 1'b1;
                        state_nxt = LAUNCH;
                    end
                end
                LAUNCH: begin
                    // A finish still high from the previous channel must clear first.
                    if (!calc.calc_finish) begin
                        state_nxt = WAIT;
                        cnt_ld    = 1'b1;
                        cnt_val   = TMO_LOAD;
                    end
                end
                WAIT: begin
                    if (calc.calc_finish) begin
                        state_nxt = CAPTURE;
                    end else if (cnt_zero) begin
                        state_nxt = ERROR;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                CAPTURE: begin
                    cap = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = SELECT;
                    end else begin
                        state_nxt = GAP;
                        cnt_ld    = 1'b1;
                        cnt_val   = GAP_LOAD;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state_nxt = SELECT;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                DONE, ERROR: begin
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            snap_en       <= '0;
            snap          <= '0;
            calc_params_q <= '0;
            calc_start_q  <= 1'b0;
            new_params    <= '0;
            chan_done     <= '0;
        end else begin
            // Registered from the next state so calc_finish never reaches calc_start combinationally.
            calc_start_q <= (state_nxt == WAIT) || (state_nxt == CAPTURE);
            if (snap_ld) begin
                snap      <= params_in;
                snap_en   <= chan_en;
                ptr       <= '0;
                chan_done <= '0;
            end
            if (skip) begin
                chan_done[ptr] <= 1'b1;
                ptr            <= ptr + 1'b1;
            end
            if (sel_ld) begin
                calc_params_q <= snap[ptr];
            end
            if (cap) begin
                new_params[ptr] <= calc.calc_result;
                chan_done[ptr]  <= 1'b1;
                ptr             <= ptr + 1'b1;
            end
            if (clr_done) begin
                chan_done <= '0;
            end
        end
    end

    assign calc.calc_start  = calc_start_q;
    assign calc.calc_params = calc_params_q;

    assign busy        = (state != IDLE) && (state != DONE) && (state != ERROR);
    assign finish      = (state == DONE);
    assign timeout_err = (state == ERROR);

endmodule

// File: tb/tb_calc_params_sequencer.sv
// Directed/randomized bench for calc_params_sequencer with a behavioural
// calculator responder and a per-channel expected-result model.
module tb_calc_params_sequencer;
    import calc_seq_pkg::*;

    localparam int W   = 32;
    localparam int NP  = 5;
    localparam int NC  = 5;
    localparam int GAP = 20;
    localparam int TMO = 64;
    localparam int LAT = 7;
    localparam int CW  = NP * W;

    typedef logic [NP-1:0][W-1:0] bank_t;
    typedef logic [NC-1:0][NP-1:0][W-1:0] all_t;
    typedef logic [CW-1:0] cv_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NC-1:0] chan_en;
    all_t          params_in;
    all_t          new_params;
    logic [NC-1:0] chan_done;
    logic          busy, finish, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    calc_params_sequencer_if #(.W(W), .NUM_PAR(NP)) cif ();

    calc_params_sequencer #(
        .W(W), .NUM_PAR(NP), .NUM_CH(NC), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .chan_en     (chan_en),
        .params_in   (params_in),
        .calc        (cif),
        .new_params  (new_params),
        .chan_done   (chan_done),
        .busy        (busy),
        .finish      (finish),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic bank_t plus1(input bank_t b);
        bank_t r;
        for (int j = 0; j < NP; j++) r[j] = b[j] + 1;
        return r;
    endfunction

    function automatic all_t rand_all();
        all_t r;
        for (int i = 0; i < NC; i++)
            for (int j = 0; j < NP; j++) r[i][j] = $urandom;
        return r;
    endfunction

    // Calculator responder: result = operands + 1 after LAT cycles; finish
    // held while calc_start is high, then for hold_cfg more cycles.
    int   hold_cfg  = 0;
    logic never_fin = 1'b0;
    int   m_lat = 0;
    int   m_hold = 0;
    logic m_active = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            cif.calc_finish = 1'b0;
            cif.calc_result = '0;
            m_active = 1'b0;
            m_hold = 0;
        end else if (m_active) begin
            if (!cif.calc_start) begin
                m_active = 1'b0;
            end else begin
                m_lat++;
                if (m_lat >= LAT && !never_fin) begin
                    cif.calc_finish = 1'b1;
                    cif.calc_result = plus1(cif.calc_params);
                    m_active = 1'b0;
                    m_hold = hold_cfg;
                end
            end
        end else if (cif.calc_start && !cif.calc_finish) begin
            m_active = 1'b1;
            m_lat = 0;
        end else if (!cif.calc_start && cif.calc_finish) begin
            if (m_hold > 0) m_hold--;
            else cif.calc_finish = 1'b0;
        end
    end

    // Launch monitor: pulse count, capture-to-launch spacing, launches over a stale finish.
    int   cyc = 0;
    int   rises = 0;
    int   gap_viol = 0;
    int   stale = 0;
    int   last_fall = -100000;
    logic prev_cs = 1'b0;
    logic prev_fin = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (cif.calc_start && !prev_cs) begin
            rises++;
            if (cyc - last_fall < GAP) gap_viol++;
            if (prev_fin) stale++;
        end
        if (!cif.calc_start && prev_cs) last_fall = prev_fin ? cyc : -100000;
        prev_cs  = cif.calc_start;
        prev_fin = cif.calc_finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t, required under 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input cv_t obs, input cv_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    all_t exp_np = '0;

    task automatic check_banks(input string tag);
        for (int i = 0; i < NC; i++)
            chk($sformatf("%s_np%0d", tag, i), cv_t'(new_params[i]), cv_t'(exp_np[i]));
    endtask

    task automatic run_full(input logic [NC-1:0] mask, input string tag);
        all_t p;
        int r0;
        int t;
        p  = rand_all();
        r0 = rises;
        params_in = p;
        chan_en   = mask;
        start     = 1'b1;
        @(negedge clk);
        params_in = rand_all();
        chan_en   = ~mask;
        t = 0;
        while (!finish && !timeout_err && t < 3000) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < NC; i++) if (mask[i]) exp_np[i] = plus1(p[i]);
        chk({tag, "_finish"}, cv_t'(finish), cv_t'(1));
        chk({tag, "_busy"}, cv_t'(busy), cv_t'(0));
        chk({tag, "_chan_done"}, cv_t'(chan_done), cv_t'({NC{1'b1}}));
        chk({tag, "_pulses"}, cv_t'(rises - r0), cv_t'($countones(mask)));
        check_banks(tag);
    endtask

    task automatic leave_done(input string tag);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_fin_clr"}, cv_t'(finish), cv_t'(0));
        chk({tag, "_done_clr"}, cv_t'(chan_done), cv_t'(0));
        check_banks({tag, "_kept"});
    endtask

    initial begin
        all_t p;
        int   t, t0, r0;
        reset = 1'b1;
        start = 1'b0;
        chan_en = '0;
        params_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", cv_t'(busy), cv_t'(0));
        chk("rst_finish", cv_t'(finish), cv_t'(0));
        chk("rst_tmo", cv_t'(timeout_err), cv_t'(0));
        chk("rst_done", cv_t'(chan_done), cv_t'(0));
        chk("rst_cstart", cv_t'(cif.calc_start), cv_t'(0));
        chk("rst_cparams", cv_t'(cif.calc_params), cv_t'(0));
        check_banks("rst");
        reset = 1'b0;
        @(negedge clk);

        run_full(5'b11111, "all");
        chk("all_gap", cv_t'(gap_viol), cv_t'(0));
        leave_done("all");

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_np = '0;
        @(negedge clk);
        run_full(NC'((1 << CH_Z) | (1 << CH_E1)), "mask");
        chk("mask_x", cv_t'(new_params[CH_X]), cv_t'(0));
        chk("mask_y", cv_t'(new_params[CH_Y]), cv_t'(0));
        chk("mask_e0", cv_t'(new_params[CH_E0]), cv_t'(0));
        leave_done("mask");

        hold_cfg = 3;
        run_full(NC'($urandom_range(1, 31)), "hold3");
        leave_done("hold3");
        hold_cfg = GAP + 5;
        run_full(5'b11111, "holdlong");
        chk("hold_stale", cv_t'(stale), cv_t'(0));
        chk("hold_gap", cv_t'(gap_viol), cv_t'(0));
        leave_done("holdlong");
        hold_cfg = 0;
        repeat (GAP + 10) @(negedge clk);

        chan_en = '0;
        params_in = rand_all();
        start = 1'b1;
        t0 = cyc;
        t = 0;
        while (!finish && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("empty_lat", cv_t'(cyc - t0), cv_t'(NC + 2));
        chk("empty_done", cv_t'(chan_done), cv_t'({NC{1'b1}}));
        check_banks("empty");
        leave_done("empty");

        never_fin = 1'b1;
        params_in = rand_all();
        chan_en = 5'b11111;
        start = 1'b1;
        t = 0;
        while (!cif.calc_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        t0 = cyc;
        t = 0;
        while (!timeout_err && t < 4 * TMO) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_lat", cv_t'(cyc - t0), cv_t'(TMO));
        chk("tmo_err", cv_t'(timeout_err), cv_t'(1));
        chk("tmo_cstart", cv_t'(cif.calc_start), cv_t'(0));
        chk("tmo_busy", cv_t'(busy), cv_t'(0));
        chk("tmo_finish", cv_t'(finish), cv_t'(0));
        start = 1'b0;
        @(negedge clk);
        chk("tmo_clr", cv_t'(timeout_err), cv_t'(0));
        chk("tmo_done_clr", cv_t'(chan_done), cv_t'(0));
        check_banks("tmo");
        never_fin = 1'b0;
        @(negedge clk);

        p = rand_all();
        r0 = rises;
        params_in = p;
        chan_en = 5'b11111;
        start = 1'b1;
        t = 0;
        while ((rises - r0) < CH_Z + 1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_ops", cv_t'(cif.calc_params), cv_t'(p[CH_Z]));
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy", cv_t'(busy), cv_t'(0));
        chk("abort_cstart", cv_t'(cif.calc_start), cv_t'(0));
        chk("abort_done", cv_t'(chan_done), cv_t'(0));
        for (int i = 0; i < CH_Z; i++) exp_np[i] = plus1(p[i]);
        check_banks("abort");
        run_full(5'b11111, "restart");
        leave_done("restart");

        r0 = rises;
        params_in = rand_all();
        chan_en = 5'b11111;
        start = 1'b1;
        t = 0;
        while ((rises - r0) < 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b1;
        @(negedge clk);
        exp_np = '0;
        chk("mrst_busy", cv_t'(busy), cv_t'(0));
        chk("mrst_cstart", cv_t'(cif.calc_start), cv_t'(0));
        chk("mrst_cparams", cv_t'(cif.calc_params), cv_t'(0));
        chk("mrst_done", cv_t'(chan_done), cv_t'(0));
        chk("mrst_finish", cv_t'(finish), cv_t'(0));
        check_banks("mrst");
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_full(NC'($urandom_range(1, 31)), "final");
        chk("final_stale", cv_t'(stale), cv_t'(0));
        leave_done("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
